// File: rtl/spike_event_collector_if.sv
// Readout stream of spike events: one {column, timestamp} per transfer.
//
// Handshake: the producer raises ev_valid whenever ev_addr/ev_time hold an
// event and keeps them stable until the consumer accepts it. A transfer
// happens on every rising clk edge where ev_valid and ev_ready are both 1.
// ev_ready may be asserted regardless of ev_valid and has no effect when
// ev_valid is low.
interface spike_event_collector_if #(
    parameter int AW       = 1,
    parameter int TS_WIDTH = 16
);
    logic                ev_valid;
    logic                ev_ready;
    logic [AW-1:0]       ev_addr;
    logic [TS_WIDTH-1:0] ev_time;

    modport master (output ev_valid, output ev_addr, output ev_time, input ev_ready);
    modport slave  (input ev_valid, input ev_addr, input ev_time, output ev_ready);
endinterface

// File: rtl/spike_event_collector.sv
// Spike event collector: timestamps per-column spikes, arbitrates columns
// round-robin into an event FIFO read out over a valid/ready stream, and
// counts spikes that could not be held.
module spike_event_collector #(
    parameter int NUM_COLS   = 2,
    parameter int TS_WIDTH   = 16,
    parameter int DEPTH      = 8,
    parameter int DROP_WIDTH = 16,
    localparam int AW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1,
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_COLS-1:0]   spike_in,
    input  logic                  ts_clear,
    spike_event_collector_if.master ev,
    output logic [LW-1:0]         fifo_level,
    output logic [DROP_WIDTH-1:0] drop_count,
    output logic                  overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = AW + TS_WIDTH;

    logic [TS_WIDTH-1:0]   ts;
    logic [NUM_COLS-1:0]   pending;
    logic [TS_WIDTH-1:0]   ts_lat [NUM_COLS];
    logic [AW-1:0]         rr_ptr;
    logic [AW-1:0]         rr_next;
    logic [EW-1:0]         mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [LW-1:0]         level;
    logic                  pop;
    logic                  can_write;
    logic                  grant_v;
    logic [AW-1:0]         grant_idx;
    logic [NUM_COLS-1:0]   drop_vec;
    logic [DROP_WIDTH:0]   drop_n;
    logic [DROP_WIDTH:0]   drop_sum;
    logic [EW-1:0]         head;

    assign pop        = ev.ev_valid & ev.ev_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign can_write  = (level < LW'(DEPTH)) | pop;
    assign head       = mem[rd_ptr];
    assign fifo_level = level;

    // Head outputs read zero while the FIFO is empty so reset shows a clean bus.
    assign ev.ev_valid = (level != '0);
    assign ev.ev_addr  = ev.ev_valid ? head[EW-1:TS_WIDTH] : '0;
    assign ev.ev_time  = ev.ev_valid ? head[TS_WIDTH-1:0]  : '0;

    // Free-running timestamp; clear wins over increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        ts <= '0;
        else if (ts_clear) ts <= '0;
        else               ts <= ts + TS_WIDTH'(1);
    end

    // Round-robin search for the first pending column starting at rr_ptr.
    always_comb begin
        int idx;
        grant_v   = 1'b0;
        grant_idx = '0;
        idx       = 0;
        if (can_write) begin
            for (int i = 0; i < NUM_COLS; i++) begin
                idx = int'(rr_ptr) + i;
                if (idx >= NUM_COLS) idx = idx - NUM_COLS;
                if (!grant_v && pending[idx]) begin
                    grant_v   = 1'b1;
                    grant_idx = AW'(idx);
                end
            end
        end
    end

    // Next round-robin start: the column after the one just granted.
    always_comb begin
        rr_next = rr_ptr;
        if (grant_v) begin
            if (int'(grant_idx) == NUM_COLS - 1) rr_next = '0;
            else                                 rr_next = grant_idx + AW'(1);
        end
    end

    // A spike is lost when its column already holds an event that is not leaving now.
    always_comb begin
        drop_n = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            drop_vec[c] = spike_in[c] & pending[c] & ~(grant_v && (grant_idx == AW'(c)));
            drop_n      = drop_n + (DROP_WIDTH + 1)'(drop_vec[c]);
        end
        drop_sum = {1'b0, drop_count} + drop_n;
    end

    // Per-column capture: one held event per column, re-armed when it is granted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
            for (int c = 0; c < NUM_COLS; c++) ts_lat[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_COLS; c++) begin
                if (spike_in[c]) begin
                    if (!pending[c] || (grant_v && (grant_idx == AW'(c)))) begin
                        pending[c] <= 1'b1;
                        ts_lat[c]  <= ts;
                    end
                end else if (grant_v && (grant_idx == AW'(c))) begin
                    pending[c] <= 1'b0;
                end
            end
        end
    end

    // Arbiter pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rr_ptr <= '0;
        else        rr_ptr <= rr_next;
    end

    // FIFO storage; contents need no reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (grant_v) mem[wr_ptr] <= {grant_idx, ts_lat[grant_idx]};
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (grant_v) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({grant_v, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Saturating drop counter and sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (drop_vec != '0) begin
            drop_count <= drop_sum[DROP_WIDTH] ? '1 : drop_sum[DROP_WIDTH-1:0];
            overflow   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_spike_event_collector.sv
// Bench for spike_event_collector: directed scenarios plus random traffic,
// scored against a queue-based reference model of the collector's rules.
module tb_spike_event_collector;
    localparam int NC = 2;
    localparam int TW = 8;
    localparam int DP = 8;
    localparam int DW = 4;
    localparam int AW = 1;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NC-1:0] spike_in = '0;
    logic          ts_clear = 1'b0;
    logic [LW-1:0] fifo_level;
    logic [DW-1:0] drop_count;
    logic          overflow;

    spike_event_collector_if #(.AW(AW), .TS_WIDTH(TW)) ev ();

    spike_event_collector #(
        .NUM_COLS(NC), .TS_WIDTH(TW), .DEPTH(DP), .DROP_WIDTH(DW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .spike_in   (spike_in),
        .ts_clear   (ts_clear),
        .ev         (ev.master),
        .fifo_level (fifo_level),
        .drop_count (drop_count),
        .overflow   (overflow)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // Scoreboard state
    int total = 0;
    int bad   = 0;
    logic [AW+TW-1:0] exp_q[$];

    // Reference model state, describing the collector during the current cycle
    int m_ts, m_level, m_rr, m_drop;
    bit m_ovf;
    bit m_pend[NC];
    int m_lat[NC];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ts = 0; m_level = 0; m_rr = 0; m_drop = 0; m_ovf = 0;
        for (int c = 0; c < NC; c++) begin
            m_pend[c] = 0;
            m_lat[c]  = 0;
        end
        exp_q.delete();
    endtask

    // Driver: apply one cycle of inputs, check status, advance the model
    task automatic cycle_body(input logic [NC-1:0] spk, input logic clr, input logic rdy);
        bit pop, cw;
        int g, nd, c;
        bit pend_before[NC];
        spike_in    = spk;
        ts_clear    = clr;
        ev.ev_ready = rdy;
        chk("fifo_level", int'(fifo_level), m_level);
        chk("drop_count", int'(drop_count), m_drop);
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("ev_valid", int'(ev.ev_valid), int'(m_level != 0));
        pop = (m_level > 0) && rdy;
        cw  = (m_level < DP) || pop;
        g   = -1;
        if (cw) begin
            for (int i = 0; i < NC; i++) begin
                c = (m_rr + i) % NC;
                if (g < 0 && m_pend[c]) g = c;
            end
        end
        pend_before = m_pend;
        if (g >= 0) begin
            exp_q.push_back((AW+TW)'((g << TW) | m_lat[g]));
            m_pend[g] = 0;
            m_rr = (g + 1) % NC;
        end
        nd = 0;
        for (int k = 0; k < NC; k++) begin
            if (spk[k]) begin
                if (!pend_before[k] || k == g) begin
                    m_pend[k] = 1;
                    m_lat[k]  = m_ts;
                end else begin
                    nd++;
                end
            end
        end
        if (nd > 0) begin
            m_ovf  = 1;
            m_drop = (m_drop + nd > (1 << DW) - 1) ? (1 << DW) - 1 : m_drop + nd;
        end
        m_level = m_level + ((g >= 0) ? 1 : 0) - (pop ? 1 : 0);
        m_ts    = clr ? 0 : (m_ts + 1) % (1 << TW);
    endtask

    task automatic step(input logic [NC-1:0] spk, input logic clr, input logic rdy);
        @(posedge clk);
        #2;
        cycle_body(spk, clr, rdy);
    endtask

    // Monitor: pop and compare on every accepted transfer, check hold stability
    logic             hold_v = 1'b0;
    logic [AW+TW-1:0] hold_d = '0;
    always @(negedge clk) begin
        logic [AW+TW-1:0] e;
        if (reset) begin
            if (hold_v) chk("hold_stable", int'({ev.ev_addr, ev.ev_time}), int'(hold_d));
            if (ev.ev_valid && ev.ev_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", int'({ev.ev_addr, ev.ev_time}), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("ev_addr", int'(ev.ev_addr), int'(e[AW+TW-1:TW]));
                    chk("ev_time", int'(ev.ev_time), int'(e[TW-1:0]));
                end
            end
            hold_v = ev.ev_valid && !ev.ev_ready;
            hold_d = {ev.ev_addr, ev.ev_time};
        end else begin
            hold_v = 1'b0;
        end
    end

    // Stimulus
    initial begin
        int x;
        logic [NC-1:0] spk;
        logic rdy, clr;
        ev.ev_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_ev_valid", int'(ev.ev_valid), 0);
        chk("rst_ev_addr", int'(ev.ev_addr), 0);
        chk("rst_ev_time", int'(ev.ev_time), 0);
        chk("rst_fifo_level", int'(fifo_level), 0);
        chk("rst_drop_count", int'(drop_count), 0);
        chk("rst_overflow", int'(overflow), 0);
        model_reset();
        reset = 1'b1;
        cycle_body('0, 1'b0, 1'b0);

        // Single spike latency and timestamp
        step(2'b00, 1'b1, 1'b0);
        while (m_ts != 5) step(2'b00, 1'b0, 1'b0);
        step(2'b10, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        chk("t1_valid", int'(ev.ev_valid), 1);
        chk("t1_addr", int'(ev.ev_addr), 1);
        chk("t1_time", int'(ev.ev_time), 5);
        repeat (3) step(2'b00, 1'b0, 1'b1);
        chk("t1_level", int'(fifo_level), 0);

        // Round-robin order and pointer rotation
        while (m_ts != 9) step(2'b00, 1'b0, 1'b1);
        step(2'b11, 1'b0, 1'b1);
        repeat (4) step(2'b00, 1'b0, 1'b1);
        step(2'b01, 1'b0, 1'b1);
        while (m_ts != 20) step(2'b00, 1'b0, 1'b1);
        step(2'b11, 1'b0, 1'b1);
        step(2'b00, 1'b0, 1'b1);
        step(2'b00, 1'b0, 1'b1);
        chk("t2_first_addr", int'(ev.ev_addr), 1);
        chk("t2_first_time", int'(ev.ev_time), 20);
        step(2'b00, 1'b0, 1'b1);
        chk("t2_second_addr", int'(ev.ev_addr), 0);
        chk("t2_second_time", int'(ev.ev_time), 20);
        repeat (3) step(2'b00, 1'b0, 1'b1);

        // Fill, backpressure, single drop
        for (int i = 0; i < 8; i++) step((i % 2) ? 2'b10 : 2'b01, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        chk("t3_full_level", int'(fifo_level), 8);
        step(2'b01, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        chk("t3_drop_count", int'(drop_count), 1);
        chk("t3_overflow", int'(overflow), 1);

        // Full FIFO: pop and push on the same edge
        step(2'b10, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b1);
        step(2'b00, 1'b0, 1'b0);
        chk("t4_level_held", int'(fifo_level), 8);
        repeat (12) step(2'b00, 1'b0, 1'b1);
        chk("t4_drained", int'(fifo_level), 0);
        chk("t4_drop_unchanged", int'(drop_count), 1);

        // Timestamp wrap and clear coinciding with a spike
        while (m_ts != 255) step(2'b00, 1'b0, 1'b1);
        step(2'b01, 1'b0, 1'b1);
        step(2'b10, 1'b0, 1'b1);
        step(2'b00, 1'b0, 1'b1);
        chk("t5_wrap_time0", int'(ev.ev_time), 255);
        step(2'b00, 1'b0, 1'b1);
        chk("t5_wrap_time1", int'(ev.ev_time), 0);
        x = m_ts;
        step(2'b01, 1'b1, 1'b1);
        step(2'b10, 1'b0, 1'b1);
        step(2'b00, 1'b0, 1'b1);
        chk("t5_clear_pre_ts", int'(ev.ev_time), x);
        step(2'b00, 1'b0, 1'b1);
        chk("t5_clear_post_ts", int'(ev.ev_time), 0);
        repeat (3) step(2'b00, 1'b0, 1'b1);

        // Random traffic with alternating light and heavy backpressure
        for (int i = 0; i < 500; i++) begin
            spk = ($urandom_range(0, 1) == 0) ? NC'($urandom_range(0, 3)) : '0;
            if ((i / 50) % 2 == 1) rdy = ($urandom_range(0, 3) != 0);
            else                   rdy = ($urandom_range(0, 4) == 0);
            clr = ($urandom_range(0, 63) == 0);
            step(spk, clr, rdy);
        end
        repeat (20) step(2'b00, 1'b0, 1'b1);
        chk("rand_queue_empty", exp_q.size(), 0);

        // Asynchronous reset in the middle of a drain
        step(2'b01, 1'b0, 1'b0);
        step(2'b10, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b1);
        @(posedge clk);
        #4;
        reset = 1'b0;
        #1;
        chk("t6_valid", int'(ev.ev_valid), 0);
        chk("t6_level", int'(fifo_level), 0);
        chk("t6_drop_count", int'(drop_count), 0);
        chk("t6_overflow", int'(overflow), 0);
        model_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        cycle_body('0, 1'b0, 1'b1);
        repeat (5) step(2'b00, 1'b0, 1'b1);
        chk("t6_no_stale", int'(fifo_level), 0);

        chk("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
